instr_mem_sync: RTL and testbench
=================================

// Module: instr_mem_sync
// PURPOSE
//  Parametrised, synchronous successor to the single-cycle instruction ROM. Holds the program in a
//  DEPTH-word array, serves fetches with one-cycle registered latency through a req/valid/stall
//  handshake, supports in-system program loading, and flags misaligned or out-of-range PCs.
//  Sits between the PC/fetch stage and the decode stage of the core.
// PARAMETERS
//  DATA_W     32            instruction width in bits
//  DEPTH      256           number of instruction words (power of two, >= 2)
//  TEXT_BASE  32'h00400000  byte address of word 0 (.text start)
//  NOP_INSTR  32'h00000013  word returned on a fault (addi x0,x0,0)
// PORTS
//  clk          in   1                 rising-edge clock
//  rst_n        in   1                 asynchronous reset, active low
//  load_we      in   1                 write load_data to mem[load_idx] (honoured only in LOAD)
//  load_idx     in   $clog2(DEPTH)     word index for the load write
//  load_data    in   DATA_W            word to write
//  load_done    in   1                 pulse: LOAD -> RUN
//  load_start   in   1                 pulse: RUN/FAULT -> LOAD (reprogram)
//  fetch_req    in   1                 fetch request, sampled when fetch_ready=1
//  fetch_addr   in   32                byte address (PC)
//  fetch_stall  in   1                 downstream cannot accept; hold current output
//  fetch_ready  out  1                 block accepts fetch_req this cycle
//  fetch_valid  out  1                 instr/fault outputs are valid
//  instr        out  DATA_W            fetched word
//  fetch_fault  out  1                 accompanying fetch was misaligned or out of range
//  load_count   out  $clog2(DEPTH)+1   words written since entering LOAD (saturates at DEPTH)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=LOAD, fetch_valid=0, fetch_ready=0, instr=NOP_INSTR,
//    fetch_fault=0, load_count=0. Memory contents are NOT cleared.
//  - States: LOAD, RUN, FAULT. LOAD--load_done-->RUN; RUN--faulting fetch accepted-->FAULT;
//    RUN/FAULT--load_start-->LOAD. load_done outside LOAD and load_start inside LOAD are ignored.
//  - LOAD: fetch_ready=0, fetch_valid=0. load_we writes mem[load_idx] at the clock edge;
//    load_count increments per write, saturating at DEPTH. load_done and load_we in the same
//    cycle: the write completes, then state=RUN. Entering LOAD clears load_count.
//  - RUN: fetch_ready = !(fetch_valid && fetch_stall). On accept (fetch_req && fetch_ready):
//    offset = fetch_addr - TEXT_BASE (32-bit, wrap-around); idx = offset>>2. Next cycle:
//    fetch_valid=1, instr=mem[idx], fetch_fault=0. Back-to-back accepts give one word per cycle.
//  - Fault: offset[1:0]!=0 (misaligned) or idx>=DEPTH (includes fetch_addr<TEXT_BASE via wrap).
//    Next cycle: fetch_valid=1, instr=NOP_INSTR, fetch_fault=1; state=FAULT.
//  - FAULT: fetch_ready=0; fault output held until consumed (no stall), then fetch_valid=0.
//    Exit only through load_start or reset.
//  - Stall: while fetch_valid && fetch_stall, instr/fetch_fault/fetch_valid hold unchanged.
//    No stall and no accept: fetch_valid drops to 0 next cycle.
//  - load_start while fetch_valid=1: output is discarded (fetch_valid=0 next cycle), state=LOAD.
//  - load_start and fetch_req in the same RUN cycle: load_start wins; request not accepted.
//  - rst_n asserted mid-fetch or mid-load: immediate return to reset values; partial load
//    writes already made remain in memory.
// TESTING
//  - Load 3 words {0x10010437,0x00442483,0x009484b3} at idx 0..2, pulse load_done ->
//    load_count=3, state RUN, fetch_ready=1.
//  - Fetch 0x00400000,0x00400004,0x00400008 back-to-back -> fetch_valid on cycles 1..3 with the
//    three words in order, fetch_fault=0.
//  - Fetch 0x00400004 with fetch_stall=1 for 3 cycles -> instr=0x00442483 held,
//    fetch_ready=0; second request during stall not accepted.
//  - Fetch 0x00400006 (misaligned) -> instr=0x00000013, fetch_fault=1, FAULT; then
//    fetch_ready=0 until load_start.
//  - Fetch TEXT_BASE+4*DEPTH and 0x003FFFFC -> each faults (run separately after reload).
//  - Assert rst_n=0 mid-LOAD after 2 writes -> outputs at reset values immediately;
//    load_count=0; previously written words still readable after load_done.

Source files
------------

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory with in-system program load.
// One-cycle registered fetch path with req/valid/stall handshake and PC fault detection.
module instr_mem_sync #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_done,
  input  logic                     load_start,
  input  logic                     fetch_req,
  input  logic [31:0]              fetch_addr,
  input  logic                     fetch_stall,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [DATA_W-1:0]        instr,
  output logic                     fetch_fault,
  output logic [$clog2(DEPTH):0]   load_count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] CNT_MAX = (IW+1)'(DEPTH);
  localparam logic [DATA_W-1:0] NOP_W = NOP_INSTR[DATA_W-1:0];

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [IW:0]       cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [31:0]   offset;
  logic [IW-1:0] idx;
  logic          bad;
  logic          hold;
  logic          accept;
  logic          mem_we;

  // Addresses below TEXT_BASE wrap to huge offsets and fail the range test.
  assign offset = fetch_addr - TEXT_BASE;
  assign idx    = offset[IW+1:2];
  assign bad    = (offset[1:0] != 2'b00) || (offset[31:IW+2] != '0);

  assign hold        = valid_q && fetch_stall;
  assign fetch_ready = (state_q == S_RUN) && !hold;
  assign accept      = fetch_req && fetch_ready && !load_start;
  assign mem_we      = (state_q == S_LOAD) && load_we && rst_n;

  assign fetch_valid = valid_q;
  assign instr       = instr_q;
  assign fetch_fault = fault_q;
  assign load_count  = cnt_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[load_idx] <= load_data;
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    fault_d = fault_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        valid_d = 1'b0;
        if (load_we && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (load_done) state_d = S_RUN;
      end
      S_RUN, S_FAULT: begin
        if (load_start) begin
          state_d = S_LOAD;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (hold) begin
          valid_d = 1'b1;
        end else if (accept) begin
          valid_d = 1'b1;
          fault_d = bad;
          instr_d = bad ? NOP_W : mem[idx];
          if (bad) state_d = S_FAULT;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      instr_q <= NOP_W;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: load, fetch, stall, faults, reload, reset.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_instr_mem_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_we;
  logic [7:0]  load_idx;
  logic [31:0] load_data;
  logic        load_done;
  logic        load_start;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] instr;
  logic        fetch_fault;
  logic [8:0]  load_count;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] W0  = 32'h1001_0437;
  localparam logic [31:0] W1  = 32'h0044_2483;
  localparam logic [31:0] W2  = 32'h0094_84b3;
  localparam logic [31:0] W5  = 32'hdead_beef;
  localparam logic [31:0] W6  = 32'h0bad_f00d;
  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_mem_sync dut (
    .clk(clk), .rst_n(rst_n),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data),
    .load_done(load_done), .load_start(load_start),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .instr(instr),
    .fetch_fault(fetch_fault), .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] i, input logic [31:0] d);
    load_we = 1'b1; load_idx = i; load_data = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic reload();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    finish_load();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_ready !== 1'b0 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b ready=%b fault=%b required 0 0 0",
               fetch_valid, fetch_ready, fetch_fault);
    end
    checks++;
    if (instr !== NOP || load_count !== 9'd0) begin
      failures++;
      $display("FAIL reset_vals: instr=%h count=%0d required %h 0", instr, load_count, NOP);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    write_word(8'd0, W0);
    write_word(8'd1, W1);
    write_word(8'd2, W2);
    checks++;
    if (load_count !== 9'd3 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_count: count=%0d ready=%b required 3 0", load_count, fetch_ready);
    end
    finish_load();
    checks++;
    if (fetch_ready !== 1'b1 || fetch_valid !== 1'b0 || load_count !== 9'd3) begin
      failures++;
      $display("FAIL load_done: ready=%b valid=%b count=%0d required 1 0 3",
               fetch_ready, fetch_valid, load_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    exp[0] = W0; exp[1] = W1; exp[2] = W2;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'h0040_0000 + 32'(4 * i);
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || instr !== exp[i] || fetch_fault !== 1'b0) begin
        failures++;
        $display("FAIL b2b_%0d: valid=%b instr=%h fault=%b required 1 %h 0",
                 i, fetch_valid, instr, fetch_fault, exp[i]);
      end
    end
    fetch_req = 1'b0;
    tick();
    checks++;
    if (fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drop: valid=%b required 0", fetch_valid);
    end
  endtask

  task automatic test_stall();
    fetch_req = 1'b1;
    fetch_addr = 32'h0040_0004;
    tick();
    fetch_stall = 1'b1;
    fetch_addr = 32'h0040_0008;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_valid !== 1'b1 || instr !== W1 || fetch_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_%0d: valid=%b instr=%h ready=%b required 1 %h 0",
                 i, fetch_valid, instr, fetch_ready, W1);
      end
      tick();
    end
    fetch_req = 1'b0;
    fetch_stall = 1'b0;
    #1;
    checks++;
    if (instr !== W1 || fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: instr=%h ready=%b required %h 1", instr, fetch_ready, W1);
    end
    tick();
    checks++;
    if (fetch_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drop: valid=%b required 0", fetch_valid);
    end
  endtask

  task automatic fault_case(input logic [31:0] addr, input string name);
    fetch_req = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_addr = 32'h0040_0000;
    checks++;
    if (fetch_valid !== 1'b1 || instr !== NOP || fetch_fault !== 1'b1 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s: valid=%b instr=%h fault=%b ready=%b required 1 %h 1 0",
               name, fetch_valid, instr, fetch_fault, fetch_ready, NOP);
    end
    tick();
    tick();
    checks++;
    if (fetch_valid !== 1'b0 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_stuck: valid=%b ready=%b required 0 0", name, fetch_valid, fetch_ready);
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_faults();
    fault_case(32'h0040_0006, "misaligned");
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (load_count !== 9'd0 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL reload_enter: count=%0d ready=%b required 0 0", load_count, fetch_ready);
    end
    finish_load();
    checks++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL reload_run: ready=%b required 1", fetch_ready);
    end
    fault_case(32'h0040_0400, "above_range");
    reload();
    fault_case(32'h003F_FFFC, "below_base");
    reload();
  endtask

  task automatic test_load_start_priority();
    fetch_req = 1'b1;
    fetch_addr = 32'h0040_0000;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    fetch_req = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL ls_priority: valid=%b ready=%b required 0 0", fetch_valid, fetch_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    write_word(8'd5, W5);
    write_word(8'd6, W6);
    checks++;
    if (load_count !== 9'd2) begin
      failures++;
      $display("FAIL midload_count: count=%0d required 2", load_count);
    end
    load_we = 1'b1; load_idx = 8'd7; load_data = 32'h1234_5678;
    rst_n = 1'b0;
    #1;
    checks++;
    if (load_count !== 9'd0 || fetch_valid !== 1'b0 || instr !== NOP) begin
      failures++;
      $display("FAIL midload_reset: count=%0d valid=%b instr=%h required 0 0 %h",
               load_count, fetch_valid, instr, NOP);
    end
    tick();
    load_we = 1'b0;
    rst_n = 1'b1;
    tick();
    finish_load();
    fetch_req = 1'b1;
    fetch_addr = 32'h0040_0014;
    tick();
    fetch_addr = 32'h0040_0018;
    checks++;
    if (instr !== W5 || fetch_valid !== 1'b1) begin
      failures++;
      $display("FAIL keep_w5: instr=%h valid=%b required %h 1", instr, fetch_valid, W5);
    end
    tick();
    fetch_addr = 32'h0040_0000;
    checks++;
    if (instr !== W6) begin
      failures++;
      $display("FAIL keep_w6: instr=%h required %h", instr, W6);
    end
    tick();
    fetch_req = 1'b0;
    checks++;
    if (instr !== W0 || fetch_fault !== 1'b0) begin
      failures++;
      $display("FAIL keep_w0: instr=%h fault=%b required %h 0", instr, fetch_fault, W0);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    load_we = 1'b0; load_idx = '0; load_data = '0;
    load_done = 1'b0; load_start = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
    #2;
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_faults();
    test_load_start_priority();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
